// File: rtl/stage1_log2_approx.sv
// -----------------------------------------------------------------------------
// stage1_log2_approx
//
// First stage of the log-domain arithmetic pipeline. It computes a registered
// Mitchell-style approximation of log2(in_0) for signed Q6.10 operands, and it
// registers both raw operands next to the result. Later stages therefore see
// the original values aligned with log_in_0.
//
// The approximation for a positive input is:
//   p    = position of the leading one in in_0[W-2:0]
//   k    = p - FRAC                      (integer part of the log)
//   frac = remaining mantissa bits, normalised so that bit p-1 lands on the
//          top fraction bit (bits shifted out on the right are truncated)
//   log  = {k, frac}
// A zero or negative input cannot be represented, so it produces the marker
// {1'b1, 0...0}, which is the most negative Q6.10 value (-32.0, "minus
// infinity").
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high, has priority over en
//   en           in   stage enable; every output register holds while en=0
//   valid_in     in   qualifies in_0/in_1 (there is no backpressure)
//   in_0  [W]    in   operand whose log2 is computed, signed Q6.10
//   in_1  [W]    in   second operand, passed through unchanged
//   valid_out    out  registered valid_in
//   log_in_0 [W] out  registered approx log2(in_0), signed Q6.10
//   in_0_bypass  out  registered copy of in_0
//   in_1_bypass  out  registered copy of in_1
// -----------------------------------------------------------------------------
module stage1_log2_approx #(
    parameter int W    = 16,
    parameter int FRAC = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         valid_in,
    input  logic [W-1:0] in_0,
    input  logic [W-1:0] in_1,
    output logic         valid_out,
    output logic [W-1:0] log_in_0,
    output logic [W-1:0] in_0_bypass,
    output logic [W-1:0] in_1_bypass
);

    // Width of the leading-one index into the W-1 magnitude bits, and width
    // of the integer (exponent) field of the result.
    localparam int PW = $clog2(W - 1);
    localparam int IW = W - FRAC;

    logic [PW-1:0]   w_msb_idx;
    logic            w_non_pos;
    logic [W-2:0]    w_mant;
    logic [FRAC-1:0] w_frac;
    logic [IW-1:0]   w_exp;
    logic [W-1:0]    w_log;

    logic            r_valid;
    logic [W-1:0]    r_log;
    logic [W-1:0]    r_in_0;
    logic [W-1:0]    r_in_1;

    // Priority encoder: scanning upward means the highest set bit is the
    // last assignment, so it wins.
    // NOTE: each signal of an always_comb block is given a default before
    // any conditional assignment, so no path leaves it unassigned and no
    // latch can be inferred.
    always_comb begin
        w_msb_idx = '0;
        for (int i = 0; i < W - 1; i++) begin
            if (in_0[i]) begin
                w_msb_idx = PW'(i);
            end
        end
    end

    // Zero and negative values have no logarithm.
    assign w_non_pos = in_0[W-1] | ~(|in_0[W-2:0]);

    // Mantissa: the magnitude with its leading one removed.
    assign w_mant = in_0[W-2:0] & ~((W-1)'(1) << w_msb_idx);

    // Bidirectional barrel shift. Shift left when the leading one lies at
    // or below the binary point; otherwise shift right and drop the bits
    // that fall off the end (truncation, no rounding).
    always_comb begin
        w_frac = '0;
        if (w_msb_idx <= PW'(FRAC)) begin
            w_frac = FRAC'(w_mant << (PW'(FRAC) - w_msb_idx));
        end else begin
            w_frac = FRAC'(w_mant >> (w_msb_idx - PW'(FRAC)));
        end
    end

    // The exponent lies in -FRAC .. W-2-FRAC, so it always fits the integer
    // field and the result never overflows.
    assign w_exp = IW'(w_msb_idx) - IW'(FRAC);

    assign w_log = w_non_pos ? {1'b1, {(W-1){1'b0}}} : {w_exp, w_frac};

    // Single register layer. Data loads on every enabled edge whatever
    // valid_in is; valid_out only marks which loads are meaningful.
    // NOTE: state registers use non-blocking assignments so that every
    // register samples the values that were present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_log   <= '0;
            r_in_0  <= '0;
            r_in_1  <= '0;
        end else if (en) begin
            r_valid <= valid_in;
            r_log   <= w_log;
            r_in_0  <= in_0;
            r_in_1  <= in_1;
        end
    end

    assign valid_out   = r_valid;
    assign log_in_0    = r_log;
    assign in_0_bypass = r_in_0;
    assign in_1_bypass = r_in_1;

endmodule

// File: tb/tb_stage1_log2_approx.sv
// -----------------------------------------------------------------------------
// tb_stage1_log2_approx
//
// Directed bench for stage1_log2_approx. Every clock step drives rst, en,
// valid_in and the operands, works out what the output registers must hold
// after the next rising edge, and pushes that onto a scoreboard queue. Half
// a cycle later the entry is popped and compared with the DUT outputs. The
// log2 reference is computed arithmetically (leading-one search, then a
// multiply/divide of the mantissa) rather than with a shifter.
// -----------------------------------------------------------------------------
module tb_stage1_log2_approx;

    typedef struct packed {
        logic        valid;
        logic [15:0] log_v;
        logic [15:0] b0;
        logic [15:0] b1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        valid_in;
    logic [15:0] in_0;
    logic [15:0] in_1;
    logic        valid_out;
    logic [15:0] log_in_0;
    logic [15:0] in_0_bypass;
    logic [15:0] in_1_bypass;

    exp_t        sb_q[$];
    exp_t        held;        // value the output registers hold right now
    int          n_pass  = 0;
    int          n_total = 0;

    stage1_log2_approx dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .valid_in    (valid_in),
        .in_0        (in_0),
        .in_1        (in_1),
        .valid_out   (valid_out),
        .log_in_0    (log_in_0),
        .in_0_bypass (in_0_bypass),
        .in_1_bypass (in_1_bypass)
    );

    always #5 clk = ~clk;

    // Reference log2 in Q6.10: integer part from the leading one, fraction
    // = (x - 2^p) * 1024 / 2^p rounded toward zero.
    function automatic logic [15:0] ref_log2(input logic [15:0] x);
        int p;
        int k;
        int f;
        logic [5:0] k6;
        logic [9:0] f10;
        if (x == 16'h0000 || x[15]) return 16'h8000;
        p = 0;
        for (int i = 14; i >= 0; i--) begin
            if (x[i]) begin
                p = i;
                break;
            end
        end
        k   = p - 10;
        f   = ((int'(x) - (1 << p)) * 1024) / (1 << p);
        k6  = 6'(k);
        f10 = 10'(f);
        return {k6, f10};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // One clock: drive, predict, wait for the edge, compare away from it.
    task automatic step(input logic r, input logic e, input logic v,
                        input logic [15:0] a, input logic [15:0] b,
                        input string tag);
        exp_t nxt;
        exp_t got;
        rst      = r;
        en       = e;
        valid_in = v;
        in_0     = a;
        in_1     = b;
        if (r)      nxt = '0;
        else if (e) nxt = '{valid: v, log_v: ref_log2(a), b0: a, b1: b};
        else        nxt = held;
        held = nxt;
        sb_q.push_back(nxt);
        @(posedge clk);
        #5;
        if (sb_q.size() == 0) begin
            n_total++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            got = sb_q.pop_front();
            check({tag, ".valid"}, {15'd0, valid_out}, {15'd0, got.valid});
            check({tag, ".log"},   log_in_0,    got.log_v);
            check({tag, ".b0"},    in_0_bypass, got.b0);
            check({tag, ".b1"},    in_1_bypass, got.b1);
        end
    endtask

    initial begin
        logic [15:0] x;
        held = '0;
        rst = 1'b0; en = 1'b0; valid_in = 1'b0; in_0 = '0; in_1 = '0;
        @(negedge clk);

        // Reset with en=0, then en=0 while inputs move: all stay zero.
        step(1'b1, 1'b0, 1'b1, 16'h1234, 16'h5678, "reset");
        step(1'b0, 1'b0, 1'b1, 16'h0400, 16'h0040, "hold_after_reset0");
        step(1'b0, 1'b0, 1'b0, 16'h7FFF, 16'hFFFF, "hold_after_reset1");

        // Powers of two: exact integer logs from -10.0 to +4.0.
        x = 16'h0001;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b1, 1'b1, x, 16'h0040, $sformatf("pow2_%0d", i));
            x = x << 1;
        end

        // Spot constants for the key points of the sweep.
        step(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0040, "pow2_min");
        check("pow2_min.const", log_in_0, 16'hD800);
        step(1'b0, 1'b1, 1'b1, 16'h0400, 16'h0040, "pow2_one");
        check("pow2_one.const", log_in_0, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 16'h4000, 16'h0040, "pow2_max");
        check("pow2_max.const", log_in_0, 16'h1000);

        // Fractional mantissa, including the truncating right shift.
        step(1'b0, 1'b1, 1'b1, 16'h0600, 16'h1111, "frac_1p5");
        check("frac_1p5.const", log_in_0, 16'h0200);
        step(1'b0, 1'b1, 1'b1, 16'h0003, 16'h2222, "frac_3lsb");
        check("frac_3lsb.const", log_in_0, 16'hDE00);
        step(1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h3333, "frac_trunc");
        check("frac_trunc.const", log_in_0, 16'h13FF);

        // Non-positive inputs give the minus-infinity marker; bypass intact.
        step(1'b0, 1'b1, 1'b1, 16'h0000, 16'hABCD, "zero");
        check("zero.const", log_in_0, 16'h8000);
        step(1'b0, 1'b1, 1'b1, 16'hFC00, 16'h8001, "neg_one");
        check("neg_one.const", log_in_0, 16'h8000);
        step(1'b0, 1'b1, 1'b1, 16'h8000, 16'h7FFF, "neg_max");

        // valid_in pulse: valid_out high for exactly one cycle.
        step(1'b0, 1'b1, 1'b0, 16'h0123, 16'h0001, "vpulse_pre");
        step(1'b0, 1'b1, 1'b1, 16'h0456, 16'h0002, "vpulse_on");
        check("vpulse_on.const", {15'd0, valid_out}, 16'h0001);
        step(1'b0, 1'b1, 1'b0, 16'h0789, 16'h0003, "vpulse_off");
        check("vpulse_off.const", {15'd0, valid_out}, 16'h0000);

        // Enable dropped mid-stream: everything freezes, valid_out included.
        step(1'b0, 1'b1, 1'b1, 16'h0A00, 16'h0BBB, "en_last");
        step(1'b0, 1'b0, 1'b0, 16'h0001, 16'h0CCC, "en_hold0");
        step(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0DDD, "en_hold1");
        check("en_hold.valid_frozen", {15'd0, valid_out}, 16'h0001);
        step(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0EEE, "en_back");

        // A few pseudo-random positive operands through the reference model.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'(i % 2), 16'($urandom_range(1, 16'h7FFF)),
                 16'($urandom), $sformatf("rand_%0d", i));
        end

        // Reset mid-stream with en=1: cleared, pre-reset sample never shows.
        step(1'b0, 1'b1, 1'b1, 16'h0C00, 16'h0F0F, "pre_rst");
        step(1'b1, 1'b1, 1'b1, 16'h2000, 16'h1F1F, "mid_rst");
        check("mid_rst.log_const", log_in_0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h3000, 16'h2F2F, "post_rst_hold");
        step(1'b0, 1'b1, 1'b1, 16'h0800, 16'h3F3F, "post_rst_run");
        check("post_rst_run.const", log_in_0, 16'h0400);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
